div_repsub: RTL and testbench

DIV_REPSUB -- requirements
Module: div_repsub

---
 rtl/div_repsub.sv | 129 ++++++++++++
 tb/tb_div_repsub.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/div_repsub.sv
// div_repsub: unsigned divider using repeated subtraction.
//
// Operation: start in IDLE launches a load sequence. The dividend is taken from data_in
// in the LDA cycle and the divisor in the LDB cycle. SUB then subtracts the divisor
// once per clock until the remainder is smaller than the divisor, or until the quotient
// reaches its maximum value. DONE holds the results while start stays high.
//
// Build option: DIVZ_DETECT_EN. When defined, a zero divisor goes straight from LDB to
// DONE with err=1, quotient all ones, and the remainder equal to the dividend. When it
// is undefined, err is tied to 0 and a zero divisor runs SUB until the quotient
// saturates.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   start      - operation request, sampled in IDLE and DONE
//   data_in    - dividend (LDA cycle), then divisor (LDB cycle)
//   quotient   - registered quotient
//   remainder  - registered running/final remainder
//   done       - high only in DONE
//   busy       - high in LDA, LDB and SUB
//   err        - divide-by-zero flag, valid while done is high
module div_repsub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             err
);

  localparam logic [WIDTH-1:0] QMax = '1;

  typedef enum logic [2:0] {StIdle, StLda, StLdb, StSub, StDone} state_e;

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_quot, w_quot_nxt;
  logic [WIDTH-1:0] r_rem, w_rem_nxt;
  logic [WIDTH-1:0] r_div, w_div_nxt;
  logic             w_can_sub;

  // A saturated quotient also ends SUB, so a zero divisor cannot loop forever.
  assign w_can_sub = (r_rem >= r_div) && (r_quot != QMax);

`ifdef DIVZ_DETECT_EN
  logic r_err, w_err_nxt;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_quot_nxt  = r_quot;
    w_rem_nxt   = r_rem;
    w_div_nxt   = r_div;
`ifdef DIVZ_DETECT_EN
    w_err_nxt   = r_err;
`endif
    case (r_state)
      StIdle: begin
        if (start) w_state_nxt = StLda;
      end
      StLda: begin
        w_rem_nxt   = data_in;
        w_state_nxt = StLdb;
      end
      StLdb: begin
        w_div_nxt   = data_in;
        w_quot_nxt  = '0;
        w_state_nxt = StSub;
`ifdef DIVZ_DETECT_EN
        w_err_nxt   = 1'b0;
        if (data_in == '0) begin
          w_quot_nxt  = QMax;
          w_err_nxt   = 1'b1;
          w_state_nxt = StDone;
        end
`endif
      end
      StSub: begin
        if (w_can_sub) begin
          w_rem_nxt  = r_rem - r_div;
          w_quot_nxt = r_quot + WIDTH'(1);
        end else begin
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        if (!start) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_quot  <= '0;
      r_rem   <= '0;
      r_div   <= '0;
`ifdef DIVZ_DETECT_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_quot  <= w_quot_nxt;
      r_rem   <= w_rem_nxt;
      r_div   <= w_div_nxt;
`ifdef DIVZ_DETECT_EN
      r_err   <= w_err_nxt;
`endif
    end
  end

  // Moore outputs decoded from registers only.
  assign quotient  = r_quot;
  assign remainder = r_rem;
  assign done      = (r_state == StDone);
  assign busy      = (r_state == StLda) || (r_state == StLdb) || (r_state == StSub);
`ifdef DIVZ_DETECT_EN
  assign err       = r_err;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_div_repsub.sv
// Directed testbench for div_repsub. A 16-bit instance carries most vectors. An 8-bit
// instance covers the zero-divisor saturation path when detection is not built in, which
// keeps the run short.
// Timing reference: the edge after which start is driven is E0.
module tb_div_repsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        start16, start8;
  logic [15:0] data_in;
  logic [7:0]  data_in8;
  logic [15:0] q16, r16;
  logic [7:0]  q8, r8;
  logic        done16, busy16, err16;
  logic        done8, busy8, err8;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_done, busy_cnt;

  assign data_in8 = data_in[7:0];

  always #5 clk = ~clk;

  div_repsub #(.WIDTH(16)) u_dut16 (
    .clk      (clk),
    .rst      (rst),
    .start    (start16),
    .data_in  (data_in),
    .quotient (q16),
    .remainder(r16),
    .done     (done16),
    .busy     (busy16),
    .err      (err16)
  );

  div_repsub #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst      (rst),
    .start    (start8),
    .data_in  (data_in8),
    .quotient (q8),
    .remainder(r8),
    .done     (done8),
    .busy     (busy8),
    .err      (err8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Launches one division and counts edges from E0 until done is seen (or limit expires).
  // With hold=0, start drops after E1 and the task returns once the FSM is back in IDLE.
  task automatic run_div(input bit sel8, input logic [15:0] a, input logic [15:0] b,
                         input bit hold, input int limit, output int e_done,
                         output int b_cnt);
    e_done = -1;
    b_cnt  = 0;
    if (sel8) start8 = 1'b1;
    else      start16 = 1'b1;
    for (int n = 1; n <= limit; n++) begin
      tick();
      if (sel8 ? busy8 : busy16) b_cnt++;
      if (sel8 ? done8 : done16) begin
        e_done = n;
        break;
      end
      if (n == 1) begin
        data_in = a;
        if (!hold) begin
          start8  = 1'b0;
          start16 = 1'b0;
        end
      end
      if (n == 2) data_in = b;
    end
    if (!hold) tick();
  endtask

  initial begin
    rst     = 1'b1;
    start16 = 1'b0;
    start8  = 1'b0;
    data_in = '0;
    tick();
    tick();
    check_eq("rst_quotient", q16, 0);
    check_eq("rst_remainder", r16, 0);
    check_eq("rst_done", done16, 0);
    check_eq("rst_busy", busy16, 0);
    check_eq("rst_err", err16, 0);
    rst = 1'b0;
    tick();
    check_eq("idle_busy", busy16, 0);

    // 17 / 5
    run_div(1'b0, 16'd17, 16'd5, 1'b0, 30, edge_done, busy_cnt);
    check_eq("d17_5_done_edge", edge_done, 7);
    check_eq("d17_5_busy_cycles", busy_cnt, 6);
    check_eq("d17_5_q", q16, 3);
    check_eq("d17_5_r", r16, 2);
    check_eq("d17_5_err", err16, 0);
    check_eq("d17_5_idle_done", done16, 0);

    // Dividend smaller than divisor
    run_div(1'b0, 16'd5, 16'd17, 1'b0, 30, edge_done, busy_cnt);
    check_eq("d5_17_done_edge", edge_done, 4);
    check_eq("d5_17_q", q16, 0);
    check_eq("d5_17_r", r16, 5);

    // Zero dividend
    run_div(1'b0, 16'd0, 16'd7, 1'b0, 30, edge_done, busy_cnt);
    check_eq("d0_7_done_edge", edge_done, 4);
    check_eq("d0_7_q", q16, 0);
    check_eq("d0_7_r", r16, 0);

    // Full-range quotient, no wrap
    run_div(1'b0, 16'd65535, 16'd1, 1'b0, 65560, edge_done, busy_cnt);
    check_eq("d65535_1_done_edge", edge_done, 65539);
    check_eq("d65535_1_q", q16, 65535);
    check_eq("d65535_1_r", r16, 0);

    // Divide by zero
`ifdef DIVZ_DETECT_EN
    run_div(1'b0, 16'd40, 16'd0, 1'b1, 30, edge_done, busy_cnt);
    check_eq("divz_done_edge", edge_done, 3);
    check_eq("divz_err", err16, 1);
    check_eq("divz_q", q16, 65535);
    check_eq("divz_r", r16, 40);
    start16 = 1'b0;
    tick();
`else
    run_div(1'b1, 16'd40, 16'd0, 1'b1, 300, edge_done, busy_cnt);
    check_eq("divz8_done_edge", edge_done, 259);
    check_eq("divz8_err", err8, 0);
    check_eq("divz8_q", q8, 255);
    check_eq("divz8_r", r8, 40);
    start8 = 1'b0;
    tick();
`endif

    // 1000 / 3 aborted by a reset sampled at E100
    start16 = 1'b1;
    for (int n = 1; n <= 99; n++) begin
      tick();
      if (n == 1) begin
        data_in = 16'd1000;
        start16 = 1'b0;
      end
      if (n == 2) data_in = 16'd3;
    end
    check_eq("abort_mid_q", q16, 96);
    check_eq("abort_mid_r", r16, 712);
    check_eq("abort_mid_busy", busy16, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_q", q16, 0);
    check_eq("abort_r", r16, 0);
    check_eq("abort_done", done16, 0);
    check_eq("abort_busy", busy16, 0);
    check_eq("abort_err", err16, 0);
    tick();
    check_eq("abort_stay_idle", busy16, 0);
    run_div(1'b0, 16'd100, 16'd7, 1'b0, 40, edge_done, busy_cnt);
    check_eq("d100_7_done_edge", edge_done, 18);
    check_eq("d100_7_q", q16, 14);
    check_eq("d100_7_r", r16, 2);

    // Start held through DONE
    run_div(1'b0, 16'd17, 16'd5, 1'b1, 30, edge_done, busy_cnt);
    check_eq("hold_done_edge", edge_done, 7);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("hold_done", done16, 1);
      check_eq("hold_q", q16, 3);
      check_eq("hold_r", r16, 2);
    end
    start16 = 1'b0;
    tick();
    check_eq("release_done", done16, 0);
    check_eq("release_busy", busy16, 0);
    check_eq("release_q", q16, 3);
    check_eq("release_r", r16, 2);
    run_div(1'b0, 16'd9, 16'd2, 1'b0, 30, edge_done, busy_cnt);
    check_eq("d9_2_done_edge", edge_done, 8);
    check_eq("d9_2_q", q16, 4);
    check_eq("d9_2_r", r16, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
